// File: rtl/bnn_pkg.sv
// Shared constants and arithmetic helpers for the BinaryNet fixed-in/binary-weight layer.
// Used by the dot-product sub-module and the layer top.
package bnn_pkg;

    localparam int DEFAULT_INPUT_DIM  = 8;
    localparam int DEFAULT_OUTPUT_DIM = 4;
    localparam int DEFAULT_BIT_CNT    = 8;

    // Widest accumulator the saturation helper accepts.
    localparam int ACC_MAX = 64;

    // One extra bit beyond the growth of INPUT_DIM terms keeps negated minimums exact.
    function automatic int acc_width(input int in_dim, input int bits);
        return bits + $clog2(in_dim) + 1;
    endfunction

    function automatic logic signed [ACC_MAX-1:0] sat_to_bits(
        input logic signed [ACC_MAX-1:0] acc,
        input int unsigned               bits
    );
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end else begin
            return acc;
        end
    endfunction

endpackage

// File: rtl/bin_dot_product.sv
// Full-precision binary-weight dot product for one neuron: conditional negate of each
// sign-extended activation followed by a balanced pairwise adder tree.
module bin_dot_product #(
    parameter int INPUT_DIM = 8,
    parameter int BIT_CNT   = 8,
    parameter int ACC_W     = 12
) (
    input  logic [INPUT_DIM-1:0][BIT_CNT-1:0] value_in,
    input  logic [INPUT_DIM-1:0]              weight_row,
    output logic signed [ACC_W-1:0]           sum
);

    localparam int LEAVES = 1 << $clog2(INPUT_DIM);

    // Heap-ordered tree: node 1 is the root, leaves sit at LEAVES..2*LEAVES-1.
    logic signed [ACC_W-1:0] node [1:2*LEAVES-1];

    for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
        if (j < INPUT_DIM) begin : g_term
            logic signed [ACC_W-1:0] ext;
            assign ext = {{(ACC_W-BIT_CNT){value_in[j][BIT_CNT-1]}}, value_in[j]};
            assign node[LEAVES+j] = weight_row[j] ? ext : -ext;
        end else begin : g_pad
            assign node[LEAVES+j] = '0;
        end
    end

    for (genvar i = 1; i < LEAVES; i++) begin : g_add
        assign node[i] = node[2*i] + node[2*i+1];
    end

    assign sum = node[1];

endmodule

// File: rtl/fixed_in_bin_weight.sv
// Binary-weight fully-connected layer: one dot product per neuron, saturated to BIT_CNT
// and registered, producing a full output vector every clock.
module fixed_in_bin_weight #(
    parameter int INPUT_DIM  = bnn_pkg::DEFAULT_INPUT_DIM,
    parameter int OUTPUT_DIM = bnn_pkg::DEFAULT_OUTPUT_DIM,
    parameter int BIT_CNT    = bnn_pkg::DEFAULT_BIT_CNT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INPUT_DIM-1:0][BIT_CNT-1:0]  value_in,
    input  logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0] weight,
    output logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] value_out
);

    import bnn_pkg::*;

    localparam int ACC_W = acc_width(INPUT_DIM, BIT_CNT);

    logic signed [ACC_W-1:0]           acc [OUTPUT_DIM];
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] sat_val;

    for (genvar o = 0; o < OUTPUT_DIM; o++) begin : g_neuron
        bin_dot_product #(
            .INPUT_DIM (INPUT_DIM),
            .BIT_CNT   (BIT_CNT),
            .ACC_W     (ACC_W)
        ) u_dot (
            .value_in   (value_in),
            .weight_row (weight[o]),
            .sum        (acc[o])
        );

        assign sat_val[o] = BIT_CNT'(sat_to_bits({{(ACC_MAX-ACC_W){acc[o][ACC_W-1]}}, acc[o]},
                                                 BIT_CNT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_out <= '0;
        end else begin
            value_out <= sat_val;
        end
    end

endmodule

// File: tb/tb_fixed_in_bin_weight.sv
// Self-checking bench for fixed_in_bin_weight: directed cases from the test plan plus
// randomized streaming against an integer reference model.
module tb_fixed_in_bin_weight;

    localparam int IN  = 8;
    localparam int OUT = 4;
    localparam int BC  = 8;

    logic                       clk;
    logic                       rst;
    logic [IN-1:0][BC-1:0]      value_in;
    logic [OUT-1:0][IN-1:0]     weight;
    logic [OUT-1:0][BC-1:0]     value_out;

    int tests_run;
    int tests_failed;

    logic [BC-1:0] exp_q[$];

    fixed_in_bin_weight #(
        .INPUT_DIM  (IN),
        .OUTPUT_DIM (OUT),
        .BIT_CNT    (BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .weight    (weight),
        .value_out (value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed integer sum with +/- per weight bit, then clamp.
    function automatic logic [BC-1:0] ref_neuron(input logic [IN-1:0][BC-1:0] v,
                                                 input logic [IN-1:0] w);
        int s;
        int x;
        int lim_hi;
        int lim_lo;
        lim_hi = (1 << (BC - 1)) - 1;
        lim_lo = -(1 << (BC - 1));
        s = 0;
        for (int j = 0; j < IN; j++) begin
            x = int'($signed(v[j]));
            s = w[j] ? s + x : s - x;
        end
        if (s > lim_hi) s = lim_hi;
        if (s < lim_lo) s = lim_lo;
        return BC'(s);
    endfunction

    task automatic drive_uniform(input logic [BC-1:0] val, input logic [IN-1:0] wrow);
        @(negedge clk);
        for (int j = 0; j < IN; j++) value_in[j] = val;
        for (int o = 0; o < OUT; o++) weight[o] = wrow;
    endtask

    task automatic drive_ramp(input logic [IN-1:0] wrow);
        @(negedge clk);
        for (int j = 0; j < IN; j++) value_in[j] = BC'(j + 1);
        for (int o = 0; o < OUT; o++) weight[o] = wrow;
    endtask

    task automatic wait_result();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < IN; j++) value_in[j] = 8'd17;
        for (int o = 0; o < OUT; o++) weight[o] = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            wait_result();
            for (int o = 0; o < OUT; o++) begin
                tests_run++;
                if (value_out[o] !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL reset cyc=%0d o=%0d got=%h exp=00", c, o, value_out[o]);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < IN; j++) value_in[j] = 8'd1;
        wait_result();
        for (int o = 0; o < OUT; o++) begin
            tests_run++;
            if (value_out[o] !== 8'd8) begin
                tests_failed++;
                $display("FAIL reset_release o=%0d got=%h exp=08", o, value_out[o]);
            end
        end
    endtask

    task automatic test_basic_patterns();
        logic [BC-1:0] vals [4];
        logic [IN-1:0] rows [4];
        logic [BC-1:0] exps [4];
        vals = '{8'd1, 8'd3, 8'd5, 8'd0};
        rows = '{8'hFF, 8'h00, 8'hAA, 8'h55};
        exps = '{8'd8, 8'hE8, 8'd0, 8'd0};
        for (int t = 0; t < 4; t++) begin
            drive_uniform(vals[t], rows[t]);
            wait_result();
            for (int o = 0; o < OUT; o++) begin
                tests_run++;
                if (value_out[o] !== exps[t]) begin
                    tests_failed++;
                    $display("FAIL basic t=%0d o=%0d got=%h exp=%h", t, o, value_out[o], exps[t]);
                end
            end
        end
    endtask

    task automatic test_bit_order();
        // Element j holds j+1: 10101010 gives -1+2-3+4-5+6-7+8 = +4, 01010101 gives -4.
        drive_ramp(8'hAA);
        wait_result();
        for (int o = 0; o < OUT; o++) begin
            tests_run++;
            if (value_out[o] !== 8'd4) begin
                tests_failed++;
                $display("FAIL bit_order_aa o=%0d got=%h exp=04", o, value_out[o]);
            end
        end
        drive_ramp(8'h55);
        wait_result();
        for (int o = 0; o < OUT; o++) begin
            tests_run++;
            if (value_out[o] !== 8'hFC) begin
                tests_failed++;
                $display("FAIL bit_order_55 o=%0d got=%h exp=fc", o, value_out[o]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [BC-1:0] vals [4];
        logic [IN-1:0] rows [4];
        logic [BC-1:0] exps [4];
        vals = '{8'd127, 8'h80, 8'h80, 8'd127};
        rows = '{8'hFF, 8'hFF, 8'h00, 8'h00};
        exps = '{8'd127, 8'h80, 8'd127, 8'h80};
        for (int t = 0; t < 4; t++) begin
            drive_uniform(vals[t], rows[t]);
            wait_result();
            for (int o = 0; o < OUT; o++) begin
                tests_run++;
                if (value_out[o] !== exps[t]) begin
                    tests_failed++;
                    $display("FAIL sat t=%0d o=%0d got=%h exp=%h", t, o, value_out[o], exps[t]);
                end
            end
        end
    endtask

    task automatic test_neuron_independence();
        logic [BC-1:0] exps [OUT];
        exps = '{8'd36, 8'hDC, 8'hF0, 8'hEE};
        @(negedge clk);
        for (int j = 0; j < IN; j++) value_in[j] = BC'(j + 1);
        weight[0] = 8'hFF;
        weight[1] = 8'h00;
        weight[2] = 8'h0F;
        weight[3] = 8'h81;
        wait_result();
        for (int o = 0; o < OUT; o++) begin
            tests_run++;
            if (value_out[o] !== exps[o]) begin
                tests_failed++;
                $display("FAIL independence o=%0d got=%h exp=%h", o, value_out[o], exps[o]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [BC-1:0] exp_v;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            rst = (k == 50);
            for (int j = 0; j < IN; j++) begin
                case ($urandom_range(0, 3))
                    0: value_in[j] = 8'h80;
                    1: value_in[j] = 8'h7F;
                    default: value_in[j] = BC'($urandom_range(0, 255));
                endcase
            end
            for (int o = 0; o < OUT; o++) weight[o] = IN'($urandom);
            for (int o = 0; o < OUT; o++)
                exp_q.push_back(rst ? '0 : ref_neuron(value_in, weight[o]));
            wait_result();
            for (int o = 0; o < OUT; o++) begin
                exp_v = exp_q.pop_front();
                tests_run++;
                if (value_out[o] !== exp_v) begin
                    tests_failed++;
                    $display("FAIL stream k=%0d o=%0d got=%h exp=%h", k, o, value_out[o], exp_v);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        value_in = '0;
        weight   = '0;
        test_reset();
        test_basic_patterns();
        test_bit_order();
        test_saturation();
        test_neuron_independence();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
